dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
Controller that sequences and shares the single-port byte-addressed data memory between two requesters: the ROB commit path (stores and commit-time load re-checks) and the speculative load/store unit (LS) load path. It arbitrates, validates alignment, range and funct3, and drives one memory command per transaction. It returns the read data, or a store acknowledge, with an error flag to the granted requester. It sits between the ROB/LS units and the data memory array.

Parameters:
MEM_BYTES, 2048, memory size in bytes; valid addresses are 0..MEM_BYTES-1.
TAG_W, 5, width of the LS request tag echoed on the response.
STARVE_MAX, 4, consecutive LS losses before a forced LS grant; used only with STARVE_GUARD_EN.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
rob_req_valid  in  1  ROB request valid
rob_req_ready  out  1  ROB request accepted this cycle
rob_req_write  in  1  1 = store, 0 = load re-check
rob_req_addr  in  32  byte address
rob_req_funct3  in  3  RISC-V load/store funct3
rob_req_wdata  in  32  store data, low bytes used
ls_req_valid  in  1  LS load request valid
ls_req_ready  out  1  LS request accepted this cycle
ls_req_addr  in  32  byte address
ls_req_funct3  in  3  load funct3
ls_req_tag  in  TAG_W  LS tag
flush  in  1  kill the speculative LS transaction
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  32  memory byte address
mem_funct3  out  3  memory access size/sign
mem_wdata  out  32  memory write data
mem_rdata  in  32  read data, valid the cycle after mem_en
rob_resp_valid  out  1  ROB response, 1-cycle pulse
ls_resp_valid  out  1  LS response, 1-cycle pulse
resp_data  out  32  load data for the pulsing requester (0 for stores or errors)
resp_err  out  1  misaligned, out-of-range or illegal funct3
ls_resp_tag  out  TAG_W  tag of the completed LS request

Behaviour:
- reset low at a clk edge: state returns to IDLE; any latched transaction is discarded with no response; all outputs are 0; the starve counter is 0.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE: ready is combinational and goes to exactly one requester. ROB has priority; ls_req_ready = ls_req_valid & ~rob_req_valid & ~flush. Handshake = valid & ready. Accepting a request latches addr, funct3, wdata, write, tag and the source.
  - Legal request: go to ACCESS.
  - Illegal request: go to RESP with err=1.
- Illegal request, any of:
  - funct3 in {011, 110, 111};
  - a store with funct3 in {100, 101};
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr + size - 1 >= MEM_BYTES.
- ACCESS: mem_en=1, mem_we=latched write, mem_* driven from the latch. Go to RESP. mem_en is 0 in every other state.
- RESP: exactly one of rob_resp_valid or ls_resp_valid is 1.
  - resp_data = mem_rdata for a legal load, otherwise 0.
  - resp_err = latched err.
  - Return to IDLE.
- Throughput and latency:
  - Handshake at cycle T, memory command at T+1, response at T+2.
  - Next accept no earlier than T+3.
  - An error request responds at T+1.
- flush:
  - While an LS transaction is in ACCESS or RESP, flush sets a kill flag and ls_resp_valid is suppressed.
  - The memory read still completes, but its data and response are dropped.
  - ROB transactions ignore flush.
- Simultaneous valid on both requesters in IDLE: the ROB is granted and LS stays pending. A requester may not drop valid before its handshake.
- Address arithmetic is 32-bit and unsigned; no wrap-around is permitted (wrap counts as out-of-range).

Optional Feature:
STARVE_GUARD_EN defined:
- A counter increments each IDLE grant to ROB while ls_req_valid=1.
- It clears on an LS grant.
- At STARVE_MAX, the next IDLE cycle with ls_req_valid=1 grants LS even if ROB is valid (flush still blocks the grant).

STARVE_GUARD_EN undefined: strict ROB priority, and the counter logic is absent.

Decomposition:
- Shared package dmem_ctrl_pkg holds:
  - FSM state enum;
  - funct3 constants LB/LH/LW/LBU/LHU and SB/SH/SW;
  - source enum SRC_ROB/SRC_LS;
  - access-size function.
- One sub-module, dmem_access_check: combinational legality check (funct3, write, addr, MEM_BYTES in; err out). It is instantiated once, on the muxed winner request.

Test Plan:
- ROB store SW addr=0x10 wdata=0xDEADBEEF → T+1: mem_en=1, mem_we=1, mem_addr=0x10; T+2: rob_resp_valid=1, resp_err=0.
- LS LW addr=0x10 tag=3 after the above store, with the memory model returning 0xDEADBEEF → T+2: ls_resp_valid=1, resp_data=0xDEADBEEF, ls_resp_tag=3.
- Both valid in IDLE (ROB LB 0x20, LS LH 0x22) → ROB granted first; LS granted at T+3; LS response at T+5.
- LS LH addr=0x21 → mem_en stays 0; T+1: ls_resp_valid=1, resp_err=1, resp_data=0. Also ROB SW addr=0x7FE → resp_err=1.
- LS LW accepted at T, flush=1 at T+1 → mem_en=1 at T+1; no ls_resp_valid at T+2; ready again at T+3.
- reset=0 asserted in ACCESS → next cycle all outputs 0, state IDLE, no response pulse. With STARVE_GUARD_EN and ROB valid continuously, LS valid → LS granted on the 5th arbitration.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller: FSM states, requester ids,
// RISC-V load/store funct3 encodings and the access-size helper.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        SRC_ROB,
        SRC_LS
    } src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Bytes touched by an access; only meaningful for legal funct3 values.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request, response and memory-command bundle of the data-memory access controller.
// slave = controller side, master = requesters plus memory array side.
interface dmem_access_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             rob_req_valid;
    logic             rob_req_ready;
    logic             rob_req_write;
    logic [31:0]      rob_req_addr;
    logic [2:0]       rob_req_funct3;
    logic [31:0]      rob_req_wdata;
    logic             ls_req_valid;
    logic             ls_req_ready;
    logic [31:0]      ls_req_addr;
    logic [2:0]       ls_req_funct3;
    logic [TAG_W-1:0] ls_req_tag;
    logic             flush;
    logic             mem_en;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [2:0]       mem_funct3;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             rob_resp_valid;
    logic             ls_resp_valid;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic [TAG_W-1:0] ls_resp_tag;

    modport slave (
        input  rob_req_valid, rob_req_write, rob_req_addr, rob_req_funct3, rob_req_wdata,
        input  ls_req_valid, ls_req_addr, ls_req_funct3, ls_req_tag, flush, mem_rdata,
        output rob_req_ready, ls_req_ready,
        output mem_en, mem_we, mem_addr, mem_funct3, mem_wdata,
        output rob_resp_valid, ls_resp_valid, resp_data, resp_err, ls_resp_tag
    );

    modport master (
        output rob_req_valid, rob_req_write, rob_req_addr, rob_req_funct3, rob_req_wdata,
        output ls_req_valid, ls_req_addr, ls_req_funct3, ls_req_tag, flush, mem_rdata,
        input  rob_req_ready, ls_req_ready,
        input  mem_en, mem_we, mem_addr, mem_funct3, mem_wdata,
        input  rob_resp_valid, ls_resp_valid, resp_data, resp_err, ls_resp_tag
    );

endinterface

// File: rtl/dmem_access_check.sv
// Combinational legality check of one memory request: funct3, store size,
// natural alignment and range (no 32-bit wrap-around allowed).
module dmem_access_check
    import dmem_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = 2048
) (
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [31:0] addr,
    output logic        err
);

    logic [32:0] last_byte;
    logic        bad_funct3;
    logic        misaligned;
    logic        bad_store;

    // The 33-bit sum makes an address that wraps past 2^32 land out of range.
    always_comb begin
        last_byte  = {1'b0, addr} + 33'(access_size(funct3)) - 33'd1;
        bad_funct3 = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: misaligned = 1'b0;
            F3_LH, F3_LHU: misaligned = addr[0];
            F3_LW:         misaligned = |addr[1:0];
            default:       bad_funct3 = 1'b1;
        endcase
        bad_store = write && !(funct3 inside {F3_SB, F3_SH, F3_SW});
        err = bad_funct3 || misaligned || bad_store || (last_byte >= 33'(MEM_BYTES));
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates the single-port data memory between the ROB commit path and the LS load path.
// Define STARVE_GUARD_EN to force an LS grant after STARVE_MAX consecutive LS losses.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int MEM_BYTES  = 2048,
    parameter int TAG_W      = 5
`ifdef STARVE_GUARD_EN
    ,
    parameter int STARVE_MAX = 4
`endif
) (
    input  logic               clk,
    input  logic               reset,
    dmem_access_ctrl_if.slave  bus
);

    state_t           state;
    state_t           next_state;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [2:0]       lat_funct3;
    logic             lat_write;
    logic             lat_err;
    logic [TAG_W-1:0] lat_tag;
    src_t             lat_src;
    logic             kill;

    logic             idle_ok;
    logic             force_ls;
    logic             rob_win;
    logic             ls_win;
    logic             accept;
    logic             win_write;
    logic [31:0]      win_addr;
    logic [2:0]       win_funct3;
    logic             win_err;
    logic             rob_fire;
    logic             ls_fire;

`ifdef STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;

    // Counts ROB wins over a waiting LS request, saturating at the force threshold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (bus.ls_req_ready) begin
            starve_cnt <= '0;
        end else if (bus.rob_req_ready && bus.ls_req_valid && starve_cnt != CNT_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_ls = (starve_cnt == CNT_W'(STARVE_MAX)) && bus.ls_req_valid && !bus.flush;
`else
    assign force_ls = 1'b0;
`endif

    assign idle_ok           = (state == IDLE) && reset;
    assign rob_win           = bus.rob_req_valid && !force_ls;
    assign ls_win            = bus.ls_req_valid && !bus.flush && (!bus.rob_req_valid || force_ls);
    assign bus.rob_req_ready = idle_ok && rob_win;
    assign bus.ls_req_ready  = idle_ok && ls_win;
    assign accept            = bus.rob_req_ready || bus.ls_req_ready;

    assign win_write  = ls_win ? 1'b0 : bus.rob_req_write;
    assign win_addr   = ls_win ? bus.ls_req_addr : bus.rob_req_addr;
    assign win_funct3 = ls_win ? bus.ls_req_funct3 : bus.rob_req_funct3;

    dmem_access_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .funct3 (win_funct3),
        .write  (win_write),
        .addr   (win_addr),
        .err    (win_err)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Illegal requests skip the memory and respond straight away.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = win_err ? RESP : ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
            lat_write  <= 1'b0;
            lat_err    <= 1'b0;
            lat_tag    <= '0;
            lat_src    <= SRC_ROB;
            kill       <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                lat_addr   <= win_addr;
                lat_wdata  <= bus.rob_req_wdata;
                lat_funct3 <= win_funct3;
                lat_write  <= win_write;
                lat_err    <= win_err;
                lat_tag    <= bus.ls_req_tag;
                lat_src    <= ls_win ? SRC_LS : SRC_ROB;
                kill       <= 1'b0;
            end
        end else if (bus.flush && lat_src == SRC_LS) begin
            kill <= 1'b1;
        end
    end

    // A flush seen in the response cycle itself also drops the LS pulse.
    always_comb begin
        bus.mem_en         = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_funct3     = '0;
        bus.mem_wdata      = '0;
        bus.rob_resp_valid = 1'b0;
        bus.ls_resp_valid  = 1'b0;
        bus.resp_data      = '0;
        bus.resp_err       = 1'b0;
        bus.ls_resp_tag    = '0;
        rob_fire           = 1'b0;
        ls_fire            = 1'b0;
        case (state)
            ACCESS: begin
                bus.mem_en     = 1'b1;
                bus.mem_we     = lat_write;
                bus.mem_addr   = lat_addr;
                bus.mem_funct3 = lat_funct3;
                bus.mem_wdata  = lat_wdata;
            end
            RESP: begin
                rob_fire           = (lat_src == SRC_ROB);
                ls_fire            = (lat_src == SRC_LS) && !kill && !bus.flush;
                bus.rob_resp_valid = rob_fire;
                bus.ls_resp_valid  = ls_fire;
                if (rob_fire || ls_fire) begin
                    bus.resp_err = lat_err;
                    if (!lat_write && !lat_err) bus.resp_data = bus.mem_rdata;
                end
                if (ls_fire) bus.ls_resp_tag = lat_tag;
            end
            default: ;
        endcase
    end

endmodule
